// File: rtl/mc_controller_if.sv
// ============================================================================
// Module   : mc_controller_if
// Purpose  : Opcode/flag inputs and control outputs of the multicycle control FSM.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface mc_controller_if #(
  parameter int CNT_W = 32
);
  logic [5:0]       op;
  logic             zero;
  logic             pcen;
  logic             memwrite;
  logic             irwrite;
  logic             regwrite;
  logic             iord;
  logic             memtoreg;
  logic             regdst;
  logic             alusrca;
  logic [2:0]       alusrcb;
  logic [1:0]       pcsrc;
  logic [1:0]       aluop;
  logic             instr_done;
  logic             illegal_op;
  logic [CNT_W-1:0] retired;

  modport master (
    output op, zero,
    input  pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst,
           alusrca, alusrcb, pcsrc, aluop, instr_done, illegal_op, retired
  );

  modport slave (
    input  op, zero,
    output pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst,
           alusrca, alusrcb, pcsrc, aluop, instr_done, illegal_op, retired
  );
endinterface

`default_nettype wire

// File: rtl/mc_controller.sv
// ============================================================================
// Module   : mc_controller
// Purpose  : Moore control FSM sequencing the multicycle MIPS datapath.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mc_controller #(
  parameter int CNT_W = 32
) (
  input  wire logic        clk,
  input  wire logic        reset,
  mc_controller_if.slave   bus
);

  localparam logic [5:0] c_OP_LW    = 6'b100011;
  localparam logic [5:0] c_OP_SW    = 6'b101011;
  localparam logic [5:0] c_OP_RTYPE = 6'b000000;
  localparam logic [5:0] c_OP_BEQ   = 6'b000100;
  localparam logic [5:0] c_OP_ADDI  = 6'b001000;
  localparam logic [5:0] c_OP_ORI   = 6'b001101;
  localparam logic [5:0] c_OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ORIEX   = 4'd10,
    S_IWB     = 4'd11,
    S_JUMP    = 4'd12
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_retired;

  logic       w_pcwrite;
  logic       w_branch;
  logic       w_memwrite;
  logic       w_irwrite;
  logic       w_regwrite;
  logic       w_iord;
  logic       w_memtoreg;
  logic       w_regdst;
  logic       w_alusrca;
  logic [2:0] w_alusrcb;
  logic [1:0] w_pcsrc;
  logic [1:0] w_aluop;
  logic       w_instr_done;
  logic       w_illegal_op;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next       = S_FETCH;
    w_pcwrite    = 1'b0;
    w_branch     = 1'b0;
    w_memwrite   = 1'b0;
    w_irwrite    = 1'b0;
    w_regwrite   = 1'b0;
    w_iord       = 1'b0;
    w_memtoreg   = 1'b0;
    w_regdst     = 1'b0;
    w_alusrca    = 1'b0;
    w_alusrcb    = 3'b000;
    w_pcsrc      = 2'b00;
    w_aluop      = 2'b00;
    w_instr_done = 1'b0;
    w_illegal_op = 1'b0;

    case (r_state)
      S_FETCH: begin
        w_irwrite = 1'b1;
        w_pcwrite = 1'b1;
        w_alusrcb = 3'b001;
        w_next    = S_DECODE;
      end
      S_DECODE: begin
        // Precompute the branch target into ALUOut while the opcode resolves.
        w_alusrcb = 3'b011;
        case (bus.op)
          c_OP_LW,
          c_OP_SW:    w_next = S_MEMADR;
          c_OP_RTYPE: w_next = S_EXECUTE;
          c_OP_BEQ:   w_next = S_BRANCH;
          c_OP_ADDI:  w_next = S_ADDIEX;
          c_OP_ORI:   w_next = S_ORIEX;
          c_OP_J:     w_next = S_JUMP;
          default: begin
            w_illegal_op = 1'b1;
            w_next       = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        w_alusrca = 1'b1;
        w_alusrcb = 3'b010;
        w_next    = (bus.op == c_OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        w_iord = 1'b1;
        w_next = S_MEMWB;
      end
      S_MEMWB: begin
        w_memtoreg   = 1'b1;
        w_regwrite   = 1'b1;
        w_instr_done = 1'b1;
      end
      S_MEMWR: begin
        w_iord       = 1'b1;
        w_memwrite   = 1'b1;
        w_instr_done = 1'b1;
      end
      S_EXECUTE: begin
        w_alusrca = 1'b1;
        w_aluop   = 2'b10;
        w_next    = S_ALUWB;
      end
      S_ALUWB: begin
        w_regdst     = 1'b1;
        w_regwrite   = 1'b1;
        w_instr_done = 1'b1;
      end
      S_BRANCH: begin
        w_alusrca    = 1'b1;
        w_aluop      = 2'b01;
        w_pcsrc      = 2'b01;
        w_branch     = 1'b1;
        w_instr_done = 1'b1;
      end
      S_ADDIEX: begin
        w_alusrca = 1'b1;
        w_alusrcb = 3'b010;
        w_next    = S_IWB;
      end
      S_ORIEX: begin
        w_alusrca = 1'b1;
        w_alusrcb = 3'b100;
        w_aluop   = 2'b11;
        w_next    = S_IWB;
      end
      S_IWB: begin
        w_regwrite   = 1'b1;
        w_instr_done = 1'b1;
      end
      S_JUMP: begin
        w_pcsrc      = 2'b10;
        w_pcwrite    = 1'b1;
        w_instr_done = 1'b1;
      end
      default: begin
        w_next = S_FETCH;
      end
    endcase
  end

  // Reset wins over a retiring state, so an interrupted instruction is not counted.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_retired <= '0;
    end else if (w_instr_done) begin
      r_retired <= r_retired + CNT_W'(1);
    end
  end

  assign bus.pcen       = w_pcwrite | (w_branch & bus.zero);
  assign bus.memwrite   = w_memwrite;
  assign bus.irwrite    = w_irwrite;
  assign bus.regwrite   = w_regwrite;
  assign bus.iord       = w_iord;
  assign bus.memtoreg   = w_memtoreg;
  assign bus.regdst     = w_regdst;
  assign bus.alusrca    = w_alusrca;
  assign bus.alusrcb    = w_alusrcb;
  assign bus.pcsrc      = w_pcsrc;
  assign bus.aluop      = w_aluop;
  assign bus.instr_done = w_instr_done;
  assign bus.illegal_op = w_illegal_op;
  assign bus.retired    = r_retired;

endmodule

`default_nettype wire

// File: tb/tb_mc_controller.sv
// ============================================================================
// Module   : tb_mc_controller
// Purpose  : Directed-vector bench for mc_controller (32-bit and 4-bit counters).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mc_controller;

  // Control word: pcen memwrite irwrite regwrite iord memtoreg regdst alusrca
  //               alusrcb[2:0] pcsrc[1:0] aluop[1:0] instr_done illegal_op
  localparam logic [16:0] c_FETCH   = 17'b1_0_1_0_0_0_0_0_001_00_00_0_0;
  localparam logic [16:0] c_DECODE  = 17'b0_0_0_0_0_0_0_0_011_00_00_0_0;
  localparam logic [16:0] c_DECILL  = 17'b0_0_0_0_0_0_0_0_011_00_00_0_1;
  localparam logic [16:0] c_MEMADR  = 17'b0_0_0_0_0_0_0_1_010_00_00_0_0;
  localparam logic [16:0] c_MEMRD   = 17'b0_0_0_0_1_0_0_0_000_00_00_0_0;
  localparam logic [16:0] c_MEMWB   = 17'b0_0_0_1_0_1_0_0_000_00_00_1_0;
  localparam logic [16:0] c_MEMWR   = 17'b0_1_0_0_1_0_0_0_000_00_00_1_0;
  localparam logic [16:0] c_EXECUTE = 17'b0_0_0_0_0_0_0_1_000_00_10_0_0;
  localparam logic [16:0] c_ALUWB   = 17'b0_0_0_1_0_0_1_0_000_00_00_1_0;
  localparam logic [16:0] c_BRTAKEN = 17'b1_0_0_0_0_0_0_1_000_01_01_1_0;
  localparam logic [16:0] c_BRNOT   = 17'b0_0_0_0_0_0_0_1_000_01_01_1_0;
  localparam logic [16:0] c_ADDIEX  = 17'b0_0_0_0_0_0_0_1_010_00_00_0_0;
  localparam logic [16:0] c_ORIEX   = 17'b0_0_0_0_0_0_0_1_100_00_11_0_0;
  localparam logic [16:0] c_IWB     = 17'b0_0_0_1_0_0_0_0_000_00_00_1_0;
  localparam logic [16:0] c_JUMP    = 17'b1_0_0_0_0_0_0_0_000_10_00_1_0;

  localparam logic [5:0] c_LW    = 6'b100011;
  localparam logic [5:0] c_SW    = 6'b101011;
  localparam logic [5:0] c_RTYPE = 6'b000000;
  localparam logic [5:0] c_BEQ   = 6'b000100;
  localparam logic [5:0] c_ADDI  = 6'b001000;
  localparam logic [5:0] c_ORI   = 6'b001101;
  localparam logic [5:0] c_J     = 6'b000010;
  localparam logic [5:0] c_JUNK  = 6'b111111;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;
  int   exp_ret;

  mc_controller_if #(.CNT_W(32)) bus ();
  mc_controller_if #(.CNT_W(4))  bus4 ();

  mc_controller #(.CNT_W(32)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  mc_controller #(.CNT_W(4)) u_dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus4.slave)
  );

  assign bus4.op   = bus.op;
  assign bus4.zero = bus.zero;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [16:0] ctrl_word();
    return {bus.pcen, bus.memwrite, bus.irwrite, bus.regwrite, bus.iord,
            bus.memtoreg, bus.regdst, bus.alusrca, bus.alusrcb, bus.pcsrc,
            bus.aluop, bus.instr_done, bus.illegal_op};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one instruction from FETCH. op is valid only in DECODE/MEMADR and junk
  // elsewhere, which also confirms op is ignored outside those states.
  task automatic run(input string tag, input logic [5:0] o, input logic z, input int n,
                     input logic [16:0] w0, input logic [16:0] w1, input logic [16:0] w2,
                     input logic [16:0] w3, input logic [16:0] w4);
    logic [16:0] seq [5];
    seq[0] = w0; seq[1] = w1; seq[2] = w2; seq[3] = w3; seq[4] = w4;
    bus.zero = z;
    for (int k = 0; k < n; k++) begin
      bus.op = (k == 1 || k == 2) ? o : c_JUNK;
      #0;
      check($sformatf("%s_c%0d", tag, k), 32'(ctrl_word()), 32'(seq[k]));
      if (k == 1) bus.op = o;
      step();
    end
    bus.op = c_JUNK;
    if (seq[1] != c_DECILL) exp_ret++;
    check($sformatf("%s_ret", tag), bus.retired, 32'(exp_ret));
    check($sformatf("%s_back", tag), 32'(ctrl_word()), 32'(c_FETCH));
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    exp_ret  = 0;
    reset    = 1'b1;
    bus.op   = c_LW;
    bus.zero = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_irwrite", 32'(bus.irwrite), 32'd1);
    check("rst_pcen",    32'(bus.pcen),    32'd1);
    check("rst_alusrcb", 32'(bus.alusrcb), 32'd1);
    check("rst_retired", bus.retired,      32'd0);

    run("lw",    c_LW,    1'b0, 5, c_FETCH, c_DECODE, c_MEMADR, c_MEMRD, c_MEMWB);
    run("sw",    c_SW,    1'b0, 4, c_FETCH, c_DECODE, c_MEMADR, c_MEMWR, 17'd0);
    run("rtype", c_RTYPE, 1'b0, 4, c_FETCH, c_DECODE, c_EXECUTE, c_ALUWB, 17'd0);
    run("beq_t", c_BEQ,   1'b1, 3, c_FETCH, c_DECODE, c_BRTAKEN, 17'd0, 17'd0);
    run("beq_n", c_BEQ,   1'b0, 3, c_FETCH, c_DECODE, c_BRNOT, 17'd0, 17'd0);
    run("ori",   c_ORI,   1'b0, 4, c_FETCH, c_DECODE, c_ORIEX, c_IWB, 17'd0);
    run("addi",  c_ADDI,  1'b0, 4, c_FETCH, c_DECODE, c_ADDIEX, c_IWB, 17'd0);
    run("j",     c_J,     1'b1, 3, c_FETCH, c_DECODE, c_JUMP, 17'd0, 17'd0);
    run("ill",   c_JUNK,  1'b1, 2, c_FETCH, c_DECILL, 17'd0, 17'd0, 17'd0);

    // Reset during MEMRD of an LW: no writeback, counter cleared.
    bus.zero = 1'b0;
    bus.op   = c_LW;
    step(); step(); step();
    check("mid_memrd", 32'(ctrl_word()), 32'(c_MEMRD));
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_ret = 0;
    check("mid_fetch",    32'(ctrl_word()), 32'(c_FETCH));
    check("mid_regwrite", 32'(bus.regwrite), 32'd0);
    check("mid_retired",  bus.retired,       32'd0);
    check("mid_ret4",     32'(bus4.retired), 32'd0);

    // 16 jumps: the 4-bit counter wraps to 0 while the wide one reaches 16.
    for (int i = 0; i < 16; i++) begin
      run("wrapj", c_J, 1'b0, 3, c_FETCH, c_DECODE, c_JUMP, 17'd0, 17'd0);
      if (i == 14) check("ret4_15", 32'(bus4.retired), 32'd15);
    end
    check("ret4_wrap", 32'(bus4.retired), 32'd0);
    check("ret32_16",  bus.retired,       32'd16);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mc_controller.md
Name: mc_controller

Overview:
Main control FSM for the multicycle MIPS core. It decodes the 6-bit opcode and steps the shared datapath (one memory, one ALU) through fetch, decode, execute, memory and writeback states, one state per clock. It drives every datapath enable and mux select, and it drives the 2-bit aluop consumed by aludec. It also reports retired instructions and illegal opcodes.

Parameters:
CNT_W, 32, width of the retired-instruction counter.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
reset  in  1  synchronous, active-high reset.
op  in  6  opcode field of the instruction register.
zero  in  1  ALU zero flag, used in BRANCH.
pcen  out  1  PC write enable: pcwrite | (branch & zero).
memwrite  out  1  memory write strobe.
irwrite  out  1  instruction register load.
regwrite  out  1  register file write.
iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
memtoreg  out  1  writeback data select: 0 = ALUOut, 1 = Data.
regdst  out  1  destination register select: 0 = rt, 1 = rd.
alusrca  out  1  ALU A select: 0 = PC, 1 = A.
alusrcb  out  3  ALU B select: 000 = B, 001 = 4, 010 = SignImm, 011 = SignImm<<2, 100 = ZeroImm.
pcsrc  out  2  next-PC select: 00 = ALUResult, 01 = ALUOut, 10 = jump target.
aluop  out  2  to aludec: 00 = add, 01 = sub, 10 = funct, 11 = or.
instr_done  out  1  one-cycle pulse in the last state of each legal instruction.
illegal_op  out  1  one-cycle pulse when DECODE sees an unsupported opcode.
retired  out  CNT_W  count of instr_done pulses.

Behaviour:
- State register, 4 bits. reset=1 at a clock edge forces FETCH and clears retired to 0. This holds mid-instruction; an interrupted instruction is abandoned and is not counted.
- Outputs are Moore-decoded from state. pcen is the only output that also depends on an input (zero). Unlisted outputs are 0 in every state.
- Opcodes: LW 100011, SW 101011, RTYPE 000000, BEQ 000100, ADDI 001000, ORI 001101, J 000010.
- FETCH: irwrite=1, pcwrite=1, alusrcb=001, aluop=00. Next state DECODE.
- DECODE: alusrcb=011, aluop=00 (branch target into ALUOut).
  - LW/SW -> MEMADR.
  - RTYPE -> EXECUTE.
  - BEQ -> BRANCH.
  - ADDI -> ADDIEX.
  - ORI -> ORIEX.
  - J -> JUMP.
  - Any other opcode: illegal_op=1 this cycle, next state FETCH, no datapath write.
- MEMADR: alusrca=1, alusrcb=010. LW -> MEMRD; SW -> MEMWR.
- MEMRD: iord=1. Next state MEMWB.
- MEMWB: memtoreg=1, regwrite=1, instr_done=1. Next state FETCH.
- MEMWR: iord=1, memwrite=1, instr_done=1. Next state FETCH.
- EXECUTE: alusrca=1, alusrcb=000, aluop=10. Next state ALUWB.
- ALUWB: regdst=1, regwrite=1, instr_done=1. Next state FETCH.
- BRANCH: alusrca=1, alusrcb=000, aluop=01, pcsrc=01, branch=1 (internal), instr_done=1. Next state FETCH.
- ADDIEX: alusrca=1, alusrcb=010, aluop=00. Next state IWB.
- ORIEX: alusrca=1, alusrcb=100, aluop=11. Next state IWB.
- IWB: regwrite=1 (regdst=0, memtoreg=0), instr_done=1. Next state FETCH.
- JUMP: pcsrc=10, pcwrite=1, instr_done=1. Next state FETCH.
- Latency in cycles including FETCH:
  - LW 5.
  - SW, RTYPE, ADDI, ORI 4.
  - BEQ, J 3.
  - Illegal opcode 2.
- op is sampled only in DECODE and MEMADR. Changes to op in other states have no effect.
- retired increments by 1 on each clock edge where instr_done=1 and reset=0. It wraps from all-ones to 0 with no flag.
- Any unused state encoding returns to FETCH on the next edge with all outputs 0.
- No X is ever driven on any output.

Test Plan:
- Reset: hold reset 2 cycles with op=LW, then release. State is FETCH: irwrite=1, pcen=1, alusrcb=001, retired=0. DECODE follows on the next cycle.
- LW: op=100011. Five-cycle sequence FETCH, DECODE, MEMADR, MEMRD, MEMWB. Single regwrite=1 with memtoreg=1 in cycle 5, instr_done in cycle 5, retired=1.
- BEQ: op=000100 run twice, once with zero=1 and once with zero=0. In BRANCH, pcen=1 and pcsrc=01 when zero=1; pcen=0 when zero=0. Both runs take 3 cycles with aluop=01.
- ORI then ADDI back-to-back: ORIEX shows alusrcb=100, aluop=11; ADDIEX shows alusrcb=010, aluop=00. Each takes 4 cycles and retired advances by 2.
- Illegal opcode op=111111: illegal_op pulses in DECODE, no regwrite/memwrite/pcen after FETCH, FETCH is re-entered, retired unchanged.
- Reset mid-instruction: assert reset during MEMRD of an LW. Next state is FETCH, regwrite is never asserted, retired=0. With CNT_W=4, 16 retirements wrap retired to 0.
